// File: rtl/axil_reg_responder.sv
// rtl/axil_reg_responder.sv - AXI4-Lite slave register file with byte strobes and SLVERR decode
module axil_reg_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS   = 12
) (
  input  logic                      aclk,
  input  logic                      aresetn,

  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                s_axi_awprot,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,

  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,

  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,

  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                s_axi_arprot,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,

  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam logic [IDX_W:0] C_NUM_REGS = NUM_REGS[IDX_W:0];
  localparam logic [1:0] C_OKAY   = 2'b00;
  localparam logic [1:0] C_SLVERR = 2'b10;

  logic                  r_live;
  logic                  r_aw_held;
  logic                  r_w_held;
  logic [IDX_W-1:0]      r_aw_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                  w_awready;
  logic                  w_wready;
  logic                  w_arready;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_commit;
  logic                  w_aw_in_range;
  logic [IDX_W-1:0]      w_ar_idx;
  logic                  w_ar_in_range;
  logic                  w_unused_ok;

  // Readies stay low for one cycle after reset release via r_live.
  assign w_awready = r_live & ~r_aw_held & ~r_bvalid;
  assign w_wready  = r_live & ~r_w_held  & ~r_bvalid;
  assign w_arready = r_live & ~r_rvalid;

  assign w_aw_hs  = s_axi_awvalid & w_awready;
  assign w_w_hs   = s_axi_wvalid  & w_wready;
  assign w_ar_hs  = s_axi_arvalid & w_arready;
  assign w_commit = r_aw_held & r_w_held;

  assign w_aw_in_range = ({1'b0, r_aw_idx} < C_NUM_REGS);
  assign w_ar_idx      = s_axi_araddr[ADDR_WIDTH-1:2];
  assign w_ar_in_range = ({1'b0, w_ar_idx} < C_NUM_REGS);

  // Protection bits and the byte offset within a word carry no meaning here.
  assign w_unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_live    <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_idx  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= C_OKAY;
    end else begin
      r_live <= 1'b1;
      if (w_aw_hs) begin
        r_aw_idx  <= s_axi_awaddr[ADDR_WIDTH-1:2];
        r_aw_held <= 1'b1;
      end
      if (w_w_hs) begin
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= s_axi_wstrb;
        r_w_held <= 1'b1;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_aw_in_range ? C_OKAY : C_SLVERR;
      end else if (r_bvalid && s_axi_bready) begin
        r_bvalid <= 1'b0;
        r_bresp  <= C_OKAY;
      end
    end
  end

  // Nonblocking update means a same-edge read sees the pre-write contents.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit && w_aw_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (r_wstrb[b]) begin
          r_regs[r_aw_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rvalid <= 1'b0;
      r_rresp  <= C_OKAY;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_ar_in_range ? C_OKAY : C_SLVERR;
      r_rdata  <= w_ar_in_range ? r_regs[w_ar_idx] : '0;
    end else if (r_rvalid && s_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign s_axi_awready = w_awready;
  assign s_axi_wready  = w_wready;
  assign s_axi_arready = w_arready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;

endmodule

// File: tb/tb_axil_reg_responder.sv
// tb/tb_axil_reg_responder.sv - directed self-checking bench for axil_reg_responder
module tb_axil_reg_responder;

  logic        aclk;
  logic        aresetn;
  logic [5:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [5:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int tests_run;
  int tests_failed;

  axil_reg_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_REGS(12)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    @(negedge aclk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int n = 0; n < 50 && (awvalid || wvalid); n++) begin
      automatic logic aw_hs = awvalid & awready;
      automatic logic w_hs  = wvalid & wready;
      @(negedge aclk);
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    for (int n = 0; n < 50 && !bvalid; n++) @(negedge aclk);
    resp = bvalid ? bresp : 2'bxx;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    @(negedge aclk);
    araddr = a; arvalid = 1'b1;
    for (int n = 0; n < 50 && !arready; n++) @(negedge aclk);
    @(negedge aclk);
    arvalid = 1'b0;
    rready = 1'b1;
    for (int n = 0; n < 50 && !rvalid; n++) @(negedge aclk);
    d    = rvalid ? rdata : 32'hxxxxxxxx;
    resp = rvalid ? rresp : 2'bxx;
    @(negedge aclk);
    rready = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic [1:0]  r;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    tests_run++;
    if ({awready, wready, arready} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ready_first_cycle: got %b want 000", {awready, wready, arready});
    end
    @(negedge aclk);
    tests_run++;
    if ({awready, wready, arready} !== 3'b111) begin
      tests_failed++;
      $display("FAIL reset_ready_second_cycle: got %b want 111", {awready, wready, arready});
    end
    tests_run++;
    if ({bvalid, rvalid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_valids: got %b want 00", {bvalid, rvalid});
    end
    axi_read(6'h0C, d, r);
    tests_run++;
    if (d !== 32'h0 || r !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_read_idx3: got %h/%b want 00000000/00", d, r);
    end
  endtask

  task automatic test_aligned_write;
    logic [31:0] d;
    logic [1:0]  r;
    @(negedge aclk);
    awaddr = 6'h08; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    tests_run++;
    if ({bvalid, awready, wready} !== 3'b000) begin
      tests_failed++;
      $display("FAIL aligned_after_edge1: got bvalid/awready/wready %b want 000", {bvalid, awready, wready});
    end
    @(negedge aclk);
    tests_run++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      tests_failed++;
      $display("FAIL aligned_bvalid_edge2: got %b/%b want 1/00", bvalid, bresp);
    end
    @(negedge aclk);
    bready = 1'b0;
    tests_run++;
    if (bvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL aligned_bvalid_clear: got %b want 0", bvalid);
    end
    axi_read(6'h08, d, r);
    tests_run++;
    if (d !== 32'hDEADBEEF || r !== 2'b00) begin
      tests_failed++;
      $display("FAIL aligned_readback: got %h/%b want deadbeef/00", d, r);
    end
  endtask

  task automatic test_strobe_skew;
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(6'h0C, 32'h11223344, 4'hF, r);
    tests_run++;
    if (r !== 2'b00) begin
      tests_failed++;
      $display("FAIL skew_first_bresp: got %b want 00", r);
    end
    @(negedge aclk);
    wdata = 32'hAABBCCDD; wstrb = 4'h5; wvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0;
    repeat (2) @(negedge aclk);
    tests_run++;
    if ({awready, wready, bvalid} !== 3'b100) begin
      tests_failed++;
      $display("FAIL skew_w_held: got awready/wready/bvalid %b want 100", {awready, wready, bvalid});
    end
    awaddr = 6'h0C; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    tests_run++;
    if (bvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL skew_bvalid_early: got %b want 0", bvalid);
    end
    @(negedge aclk);
    tests_run++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      tests_failed++;
      $display("FAIL skew_bvalid: got %b/%b want 1/00", bvalid, bresp);
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    axi_read(6'h0C, d, r);
    tests_run++;
    if (d !== 32'h11BB33DD || r !== 2'b00) begin
      tests_failed++;
      $display("FAIL skew_readback: got %h/%b want 11bb33dd/00", d, r);
    end
    axi_read(6'h0A, d, r);
    tests_run++;
    if (d !== 32'hDEADBEEF || r !== 2'b00) begin
      tests_failed++;
      $display("FAIL unaligned_alias: got %h/%b want deadbeef/00", d, r);
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] exp_regs [12];
    for (int i = 0; i < 12; i++) exp_regs[i] = 32'h0;
    exp_regs[2] = 32'hDEADBEEF;
    exp_regs[3] = 32'h11BB33DD;
    axi_write(6'h30, 32'hFFFFFFFF, 4'hF, r);
    tests_run++;
    if (r !== 2'b10) begin
      tests_failed++;
      $display("FAIL oor_bresp: got %b want 10", r);
    end
    for (int i = 0; i < 12; i++) begin
      logic [5:0] a;
      a = 6'(i * 4);
      axi_read(a, d, r);
      tests_run++;
      if (d !== exp_regs[i] || r !== 2'b00) begin
        tests_failed++;
        $display("FAIL oor_reg%0d_unchanged: got %h/%b want %h/00", i, d, r, exp_regs[i]);
      end
    end
    axi_read(6'h3C, d, r);
    tests_run++;
    if (d !== 32'h0 || r !== 2'b10) begin
      tests_failed++;
      $display("FAIL oor_read: got %h/%b want 00000000/10", d, r);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] d;
    logic [1:0]  r;
    @(negedge aclk);
    awaddr = 6'h10; wdata = 32'h0000CAFE; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge aclk);
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if ({bvalid, awready, wready} !== 3'b100) begin
        tests_failed++;
        $display("FAIL bp_b_stall_cycle%0d: got bvalid/awready/wready %b want 100", c, {bvalid, awready, wready});
      end
      @(negedge aclk);
    end
    axi_read(6'h08, d, r);
    tests_run++;
    if (d !== 32'hDEADBEEF || r !== 2'b00 || bvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_read_during_b_stall: got %h/%b bvalid %b want deadbeef/00 bvalid 1", d, r, bvalid);
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    tests_run++;
    if (bvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_b_release: got %b want 0", bvalid);
    end
    araddr = 6'h10; arvalid = 1'b1; rready = 1'b0;
    @(negedge aclk);
    arvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tests_run++;
      if (rvalid !== 1'b1 || rdata !== 32'h0000CAFE || rresp !== 2'b00 || arready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_r_stall_cycle%0d: got rvalid %b rdata %h rresp %b arready %b want 1 0000cafe 00 0",
                 c, rvalid, rdata, rresp, arready);
      end
      @(negedge aclk);
    end
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
    tests_run++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_r_release: got rvalid %b arready %b want 0 1", rvalid, arready);
    end
  endtask

  task automatic test_collision_reset;
    logic [31:0] d;
    logic [1:0]  r;
    @(negedge aclk);
    awaddr = 6'h08; wdata = 32'h55667788; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 6'h08; arvalid = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0;
    tests_run++;
    if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || bvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL collision_old_value: got rvalid %b rdata %h bvalid %b want 1 deadbeef 1", rvalid, rdata, bvalid);
    end
    bready = 1'b1; rready = 1'b1;
    @(negedge aclk);
    bready = 1'b0; rready = 1'b0;
    axi_read(6'h08, d, r);
    tests_run++;
    if (d !== 32'h55667788 || r !== 2'b00) begin
      tests_failed++;
      $display("FAIL collision_new_value: got %h/%b want 55667788/00", d, r);
    end
    @(negedge aclk);
    awaddr = 6'h08; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tests_run++;
      if (bvalid !== 1'b0) begin
        tests_failed++;
        $display("FAIL midreset_bvalid_cycle%0d: got %b want 0", c, bvalid);
      end
      @(negedge aclk);
    end
    axi_read(6'h08, d, r);
    tests_run++;
    if (d !== 32'h0 || r !== 2'b00) begin
      tests_failed++;
      $display("FAIL midreset_reg2: got %h/%b want 00000000/00", d, r);
    end
    axi_read(6'h0C, d, r);
    tests_run++;
    if (d !== 32'h0 || r !== 2'b00) begin
      tests_failed++;
      $display("FAIL midreset_reg3: got %h/%b want 00000000/00", d, r);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    aresetn = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    test_reset();
    test_aligned_write();
    test_strobe_skew();
    test_out_of_range();
    test_backpressure();
    test_collision_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axil_reg_responder.md
Name: axil_reg_responder

Overview:
- AXI4-Lite slave register file: the responder end for the AXI4-Lite master in the VIP example design (init_axi_txn / compare_done / error_out).
- Accepts the master's write-then-read-back bursts and returns the stored data, so the master's compare passes.
- Out-of-range accesses return SLVERR, which exercises the master's error_out path.
- Sits beside the master inside the example top level. Shares aclk/aresetn with it.

Parameters:
- DATA_WIDTH, 32: AXI data width; must be 32 (byte-lane logic sized DATA_WIDTH/8).
- ADDR_WIDTH, 6: AXI address width; register index = addr[ADDR_WIDTH-1:2].
- NUM_REGS, 12: number of implemented registers, 1 to 2^(ADDR_WIDTH-2); higher indices decode as out of range.

Ports:
- aclk in 1: clock, all logic on rising edge.
- aresetn in 1: synchronous, active-low reset.
- s_axi_awaddr in ADDR_WIDTH: write address.
- s_axi_awprot in 3: ignored.
- s_axi_awvalid in 1, s_axi_awready out 1: write-address handshake.
- s_axi_wdata in DATA_WIDTH: write data.
- s_axi_wstrb in DATA_WIDTH/8: byte enables.
- s_axi_wvalid in 1, s_axi_wready out 1: write-data handshake.
- s_axi_bresp out 2: 2'b00 OKAY, 2'b10 SLVERR.
- s_axi_bvalid out 1, s_axi_bready in 1: write-response handshake.
- s_axi_araddr in ADDR_WIDTH: read address.
- s_axi_arprot in 3: ignored.
- s_axi_arvalid in 1, s_axi_arready out 1: read-address handshake.
- s_axi_rdata out DATA_WIDTH, s_axi_rresp out 2: read data and response.
- s_axi_rvalid out 1, s_axi_rready in 1: read-data handshake.

Behaviour:
- Reset (aresetn low at a rising edge): all registers 0; aw_held, w_held, bvalid, rvalid cleared; bresp/rresp/rdata 0.
- All ready outputs are 0 while in reset and for the first cycle after release; gate them with a registered live flag. Valids are 0 in reset.
- Reset mid-transaction discards any held AW/W, pending B and pending R. No register write occurs for an uncommitted transaction.
- Write address channel:
  - awready = live & !aw_held & !bvalid.
  - On handshake: latch awaddr, aw_held <= 1.
- Write data channel:
  - wready = live & !w_held & !bvalid.
  - On handshake: latch wdata/wstrb, w_held <= 1.
- AW and W are independent. Either may arrive first or both in the same cycle. Any inter-arrival gap is legal.
- Commit: on the edge where aw_held & w_held:
  - In range: bytes with wstrb[i]=1 update reg[idx][8i+7:8i]; all other bytes unchanged. bresp = 00.
  - Out of range (idx >= NUM_REGS): no state change, bresp = 10.
  - bvalid <= 1; aw_held, w_held <= 0.
- Write latency: AW+W handshake at edge k gives commit and bvalid high after edge k+1.
- bvalid/bresp hold until bready. The response clears on the edge where bvalid & bready.
- No new AW/W is accepted while bvalid is high. At most one write is outstanding.
- Read channel:
  - arready = live & !rvalid.
  - On handshake at edge k: rvalid <= 1, rdata <= reg[idx] (in range, rresp 00) or 0 (out of range, rresp 10). rvalid is visible after edge k.
  - rvalid/rdata/rresp hold until rready.
  - Peak read throughput is one read per 2 cycles.
- Address bits [1:0] are ignored, so unaligned addresses alias to the word.
- Simultaneous read handshake and write commit on the same register at the same edge: the read returns the pre-write value.
- Read and write paths are fully independent; neither stalls the other.
- bready/rready held low indefinitely: the block stalls that channel only. No timeout.

Test Plan:
- Reset release: all readies 0 in the first cycle, 1 in the second. bvalid = rvalid = 0. A read of idx 3 returns 0x00000000, OKAY.
- Aligned write: AW 0x08 and W 0xDEADBEEF, wstrb 0xF, in the same cycle → bvalid after 2 edges, bresp 00. Read 0x08 → 0xDEADBEEF, rresp 00.
- Byte strobes and skew: write 0x0C = 0x11223344, then W 0xAABBCCDD with wstrb 0x5 presented 3 cycles before AW 0x0C → bvalid one edge after the AW handshake. Read → 0x11BB33DD.
- Out of range with NUM_REGS=12: write 0x30 → bresp 10 and no register changes (all 12 re-read unchanged). Read 0x3C → rdata 0, rresp 10.
- Backpressure: hold bready low 5 cycles after a write → bvalid stays 1, awready/wready stay 0, and a concurrent read still completes. Hold rready low → rdata stable, arready 0.
- Collision and reset: read of 0x08 at the same edge as a commit to 0x08 → old value returned. Then assert aresetn low while AW is held → after reset no bvalid, and reg[2] reads 0.
